// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide engine with HI/LO registers
//
// Ports:
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : begin an operation (sampled only in IDLE)
//   op       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a, b     : multiplicand/dividend and multiplier/divisor (sampled with start)
//   cancel   : abort the in-flight operation (RUN or FIX)
//   wr_hi    : MTHI write enable
//   wr_lo    : MTLO write enable
//   wr_data  : MTHI/MTLO write data
//   busy     : operation in flight
//   done     : one-cycle completion pulse
//   div_zero : one-cycle pulse alongside done when a divide had b == 0
//   hi, lo   : product high/low half, or remainder/quotient
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state, state_nx;
    logic [1:0]           op_q;
    logic                 sign_a, sign_b, zero_flag;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    // op[0]==0 selects the signed variants, op[1]==1 selects divide
    logic                 in_signed, in_div_zero;
    logic [WIDTH-1:0]     mag_a_in, mag_b_in;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    always_comb begin
        in_signed   = ~op[0];
        in_div_zero = op[1] && (b == '0);
        // Negating MIN yields MIN, which read as unsigned is the correct 2^(WIDTH-1)
        mag_a_in    = (in_signed && a[WIDTH-1]) ? -a : a;
        mag_b_in    = (in_signed && b[WIDTH-1]) ? -b : b;

        // Shift-add: multiplier sits in the low half and is consumed LSB first
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        mul_next    = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: remainder high, dividend shifting out as quotient fills in low
        div_trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
        div_next    = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fix    = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix     = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix     = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = in_div_zero ? FIX : RUN;
            RUN: begin
                if (cancel)                    state_nx = IDLE;
                else if (cnt == CNT_W'(1))     state_nx = FIX;
            end
            FIX: begin
                // Divide-by-zero holds FIX one extra cycle so it reports at E0+2
                if (cancel)                    state_nx = IDLE;
                else if (cnt == '0)            state_nx = IDLE;
            end
            default:                           state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            zero_flag <= 1'b0;
            mag_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state    <= state_nx;
            busy     <= (state_nx != IDLE);
            done     <= 1'b0;
            div_zero <= 1'b0;

            // MTHI/MTLO first so a same-edge completion write overrides them
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;

            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        sign_a    <= in_signed && a[WIDTH-1];
                        sign_b    <= in_signed && b[WIDTH-1];
                        mag_b     <= mag_b_in;
                        acc       <= {{WIDTH{1'b0}}, mag_a_in};
                        zero_flag <= in_div_zero;
                        cnt       <= in_div_zero ? CNT_W'(1) : CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    if (!cancel) begin
                        acc <= op_q[1] ? div_next : mul_next;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            done <= 1'b1;
                            if (zero_flag) begin
                                div_zero <= 1'b1;
                            end else if (op_q[1]) begin
                                hi <= rem_fix;
                                lo <= quo_fix;
                            end else begin
                                hi <= prod_fix[2*WIDTH-1:WIDTH];
                                lo <= prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic         cancel = 1'b0;
    logic         wr_hi = 1'b0, wr_lo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive start for exactly one edge (E0)
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    // Edges after E0 until done is seen; -1 if not seen in the budget
    task automatic wait_done(output int lat, output logic dz, output int busy_cnt);
        lat = -1; dz = 1'b0; busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (busy) busy_cnt++;
            if (done) begin
                lat = k; dz = div_zero;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        total++;
        if ({busy, done, div_zero} !== 3'b000 || hi !== '0 || lo !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, need all 0", busy, done, div_zero, hi, lo);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_mult();
        int lat, bc; logic dz;
        start_op(2'b00, 32'hFFFFFFFD, 32'd7);
        wait_done(lat, dz, bc);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL mult_latency: got %0d need 33", lat); end
        total++;
        if (bc !== 32) begin bad++; $display("FAIL mult_busy_cycles: got %0d need 32", bc); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_in_done: got %b need 0", busy); end
        total++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            bad++; $display("FAIL mult_neg3x7: hi=%h lo=%h need FFFFFFFF FFFFFFEB", hi, lo);
        end
        step();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_width: done=%b need 0", done); end

        start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, dz, bc);
        total++;
        if (lat !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            bad++; $display("FAIL multu_max: lat=%0d hi=%h lo=%h need 33 FFFFFFFE 00000001", lat, hi, lo);
        end
        start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, dz, bc);
        total++;
        if (lat !== 33 || hi !== 32'h0 || lo !== 32'h1) begin
            bad++; $display("FAIL mult_m1xm1: lat=%0d hi=%h lo=%h need 33 0 1", lat, hi, lo);
        end
    endtask

    // Each start is issued in the done cycle of the previous op
    task automatic test_div();
        int lat, bc; logic dz;
        start_op(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, dz, bc);
        total++;
        if (lat !== 33 || dz !== 1'b0 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL div_neg7_2: lat=%0d dz=%b lo=%h hi=%h need 33 0 FFFFFFFD FFFFFFFF", lat, dz, lo, hi);
        end
        start_op(2'b11, 32'd7, 32'd2);
        wait_done(lat, dz, bc);
        total++;
        if (lat !== 33 || lo !== 32'd3 || hi !== 32'd1) begin
            bad++; $display("FAIL divu_7_2: lat=%0d lo=%h hi=%h need 33 3 1", lat, lo, hi);
        end
        start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, dz, bc);
        total++;
        if (lat !== 33 || dz !== 1'b0 || lo !== 32'h80000000 || hi !== 32'h0) begin
            bad++; $display("FAIL div_overflow: lat=%0d dz=%b lo=%h hi=%h need 33 0 80000000 0", lat, dz, lo, hi);
        end
        start_op(2'b10, 32'd100, 32'hFFFFFFF9);
        wait_done(lat, dz, bc);
        total++;
        if (lo !== 32'hFFFFFFF2 || hi !== 32'd2) begin
            bad++; $display("FAIL div_100_neg7: lo=%h hi=%h need FFFFFFF2 2", lo, hi);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic dz;
        wr_hi = 1'b1; wr_data = 32'h11;
        step();
        wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h22;
        step();
        wr_lo = 1'b0;
        total++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            bad++; $display("FAIL mthi_mtlo: hi=%h lo=%h need 11 22", hi, lo);
        end
        start_op(2'b10, 32'd5, 32'd0);
        wait_done(lat, dz, bc);
        total++;
        if (lat !== 2 || dz !== 1'b1) begin
            bad++; $display("FAIL divzero_pulse: lat=%0d dz=%b need 2 1", lat, dz);
        end
        total++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            bad++; $display("FAIL divzero_keep: hi=%h lo=%h need 11 22", hi, lo);
        end
        step();
        total++;
        if (done !== 1'b0 || div_zero !== 1'b0) begin
            bad++; $display("FAIL divzero_width: done=%b dz=%b need 0 0", done, div_zero);
        end
    endtask

    task automatic test_cancel_and_write();
        int lat, bc; logic dz; logic seen_done;
        logic [W-1:0] hi0, lo0;
        hi0 = hi; lo0 = lo;
        start_op(2'b01, 32'd3, 32'd5);
        seen_done = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) begin start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9; end
            step();
            start = 1'b0;
            if (done) seen_done = 1'b1;
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_before_cancel: busy=%b need 1", busy); end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy: busy=%b need 0", busy); end
        for (int c = 0; c < 40; c++) begin
            if (done || div_zero) seen_done = 1'b1;
            step();
        end
        total++;
        if (seen_done !== 1'b0 || hi !== hi0 || lo !== lo0) begin
            bad++; $display("FAIL cancel_quiet: done_seen=%b hi=%h lo=%h need 0 %h %h", seen_done, hi, lo, hi0, lo0);
        end
        start_op(2'b01, 32'd3, 32'd5);
        for (int c = 1; c <= 32; c++) step();
        wr_lo = 1'b1; wr_data = 32'hAA;
        step();
        wr_lo = 1'b0;
        total++;
        if (done !== 1'b1 || lo !== 32'd15 || hi !== 32'd0) begin
            bad++; $display("FAIL fix_beats_mtlo: done=%b lo=%h hi=%h need 1 f 0", done, lo, hi);
        end
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h5A5A;
        step();
        wr_hi = 1'b0; wr_lo = 1'b0;
        total++;
        if (hi !== 32'h5A5A || lo !== 32'h5A5A) begin
            bad++; $display("FAIL dual_write: hi=%h lo=%h need 5a5a 5a5a", hi, lo);
        end
    endtask

    task automatic test_async_reset();
        int lat, bc; logic dz;
        start_op(2'b00, 32'd100, 32'd100);
        for (int c = 0; c < 10; c++) step();
        #2 reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            bad++; $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h need 0", busy, done, hi, lo);
        end
        #1 reset = 1'b1;
        step();
        start_op(2'b01, 32'd2, 32'd3);
        wait_done(lat, dz, bc);
        total++;
        if (lat !== 33 || lo !== 32'd6 || hi !== 32'd0) begin
            bad++; $display("FAIL after_reset: lat=%0d lo=%h hi=%h need 33 6 0", lat, lo, hi);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel_and_write();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine with architectural HI/LO registers.
- Supersedes the separate fixed-width `multiplier` and `divisor` instances in the multicycle CPU datapath, and the HI/LO muxes and registers that follow them.
- Supports signed and unsigned MULT and DIV, plus MTHI/MTLO writes.
- Uses a start/busy/done handshake with the control FSM, a divide-by-zero flag and a cancel input.

Parameters:
- WIDTH, 32, operand width and HI/LO width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
- a  in  WIDTH  multiplicand / dividend (RegA); sampled with start.
- b  in  WIDTH  multiplier / divisor (RegB); sampled with start.
- cancel  in  1  abort the in-flight operation.
- wr_hi  in  1  MTHI write enable.
- wr_lo  in  1  MTLO write enable.
- wr_data  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse with done when a divide had b==0.
- hi  out  WIDTH  HI register: product high half / remainder.
- lo  out  WIDTH  LO register: product low half / quotient.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, div_zero, hi, lo, counter and all internal registers go to 0.
- All outputs are registered. busy = (state != IDLE).
- FSM states are IDLE, RUN and FIX.
- IDLE: start=1 at edge E0 does the following.
  - Latches op and the sign of a and b.
  - Latches magnitudes |a| and |b| (unsigned ops use the raw values). |MIN| = 2^(WIDTH-1) as an unsigned value.
  - Sets counter=WIDTH and goes to RUN.
  - A divide with b==0 goes to FIX with a zero flag set instead.
- RUN: one radix-2 step per edge, then counter decrements. After the WIDTH-th step, go to FIX.
  - Multiply step: shift-add into a 2·WIDTH accumulator.
  - Divide step: restoring shift-subtract.
- FIX (one edge):
  - Applies sign correction. For MULT, the 2·WIDTH product is negated if sign(a)^sign(b). For DIV, the quotient is negated if sign(a)^sign(b), and the remainder takes the sign of a.
  - Writes hi/lo, sets done=1 and returns to IDLE.
  - If the zero flag is set, hi/lo are NOT written, and div_zero=1 with done=1.
- Latency:
  - Normal operation: done and the new hi/lo are visible after edge E0+WIDTH+1, i.e. 33 edges for WIDTH=32.
  - Divide-by-zero: visible after edge E0+2.
- done and div_zero are exactly one cycle wide. busy is 0 in the done cycle.
- start while busy is ignored. start in the done cycle is accepted, because state is IDLE.
- Signed overflow DIV MIN/−1: lo=MIN (wraps), hi=0. No flag is raised.
- MULT/MULTU never overflow, since the full 2·WIDTH result goes to hi:lo.
- cancel=1 in RUN or FIX: go to IDLE at the next edge with no done and no div_zero; hi/lo are unchanged. cancel in IDLE has no effect.
- wr_hi/wr_lo: write wr_data at the edge in any state.
  - If the same edge is a FIX completion write, the completion value wins.
  - wr_hi and wr_lo may both be 1 at once, writing the same data to both registers.
- Operands a/b may change after E0 without effect.
- Asynchronous reset mid-operation: immediate return to IDLE; the pending result is lost.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFD (−3), b=7 -> done exactly 33 edges after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles then low.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands -> hi=0x00000000, lo=0x00000001.
3. DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Preload hi=0x11, lo=0x22 via wr_hi/wr_lo, then DIV a=5, b=0 -> done and div_zero both high for one cycle after edge E0+2; hi=0x11, lo=0x22 unchanged.
5. MULTU 3×5 started, then the following checks:
   - start with new operands at cycle 5 is ignored.
   - cancel at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged.
   - Restart and assert wr_lo=1, wr_data=0xAA on the FIX edge -> lo=15.
6. Run MULT 100×100, drive reset=0 asynchronously mid-RUN (between edges) -> busy, done, hi, lo go to 0 immediately. After release, start MULTU 2×3 -> lo=6, hi=0 after 33 edges.
